// File: rtl/step_pkg.sv
// Shared definitions for the step pulse generator: FSM state encoding and default widths.
package step_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } step_state_t;

  localparam int DEFAULT_CNT_W  = 28;
  localparam int DEFAULT_STEP_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs into the Clk domain.
module sync_2ff (
  input  logic Clk,
  input  logic Rst,
  input  logic din,
  output logic dout
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  assign dout = s2_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced single-step generator: one Clk-wide enable per qualified rising edge of StepIn,
// plus the debounced level and a wrapping count of accepted steps.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_N = 10,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int STEP_W     = DEFAULT_STEP_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              StepIn,
  output logic              StepPulse,
  output logic              StepLevel,
  output logic [STEP_W-1:0] StepCount
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

  logic step_s2;

  step_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              level_q, level_d;
  logic [STEP_W-1:0] count_q, count_d;

  sync_2ff u_sync (
    .Clk  (Clk),
    .Rst  (Rst),
    .din  (StepIn),
    .dout (step_s2)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  // A level is accepted only after it has been seen for DEBOUNCE_N consecutive cycles;
  // any sample of the old level during the wait restarts from the settled state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    count_d = count_q;
    case (state_q)
      ST_LOW: begin
        if (step_s2) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!step_s2) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
          count_d = count_q + STEP_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!step_s2) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = '0;
        end
      end
      ST_FALL_WAIT: begin
        if (step_s2) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign StepPulse = pulse_q;
  assign StepLevel = level_q;
  assign StepCount = count_q;

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Fast-domain consumer of a slow or asynchronous stepping clock, such as a divided clock or a board push-button used for manual single-step of the pipelined processor.
- Synchronises the input into the Clk domain and debounces it.
- Emits exactly one single-cycle enable pulse per qualified rising edge, so pipeline registers stay on the single fast Clk.
- Also provides the debounced level and a running step count.

Parameters:
- DEBOUNCE_N, 10: consecutive Clk cycles the synchronised input must hold a new level before it is accepted. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 28: debounce counter width.
- STEP_W, 16: width of the StepCount output.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- StepIn  input  1  asynchronous slow clock or button level.
- StepPulse  output  1  one-Clk-cycle pulse per accepted rising edge of StepIn.
- StepLevel  output  1  debounced level of StepIn.
- StepCount  output  STEP_W  number of accepted rising edges, modulo 2^STEP_W.

Behaviour:
- Reset (Rst=0, asynchronous, takes effect without a Clk edge):
  - sync flops = 0, state = LOW, debounce counter = 0.
  - StepPulse = 0, StepLevel = 0, StepCount = 0.
  - Held while Rst=0; normal operation resumes on the first Clk edge with Rst=1.
- Synchroniser:
  - Two flops, StepIn -> s1 -> s2.
  - Only s2 feeds the FSM; StepIn is never used combinationally.
- FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT.
  - LOW: if s2=1, go to RISE_WAIT with cnt=0; otherwise stay.
  - RISE_WAIT, s2=0: glitch; go to LOW, cnt=0, no pulse.
  - RISE_WAIT, s2=1, cnt==DEBOUNCE_N-1: go to HIGH; register StepPulse=1 for this cycle only; StepLevel<=1; StepCount<=StepCount+1.
  - RISE_WAIT, s2=1, otherwise: cnt<=cnt+1.
  - HIGH: if s2=0, go to FALL_WAIT with cnt=0; otherwise stay.
  - FALL_WAIT, s2=1: glitch; go to HIGH, cnt=0.
  - FALL_WAIT, s2=0, cnt==DEBOUNCE_N-1: go to LOW; StepLevel<=0; no pulse.
  - FALL_WAIT, s2=0, otherwise: cnt<=cnt+1.
- Latency:
  - Count the first Clk edge that samples StepIn=1 as edge 1.
  - With StepIn stable, StepPulse is registered high at edge DEBOUNCE_N+3 and low again at the next edge. StepLevel rises on the same edge as StepPulse.
  - The falling path is symmetric: StepLevel falls at edge DEBOUNCE_N+3 after the first low sample.
- StepPulse is registered, never wider than one cycle, and never asserted on consecutive cycles. The minimum spacing between pulses is 2*(DEBOUNCE_N+1) cycles.
- StepCount wraps from 2^STEP_W-1 to 0 with no flag. It increments only in the cycle StepPulse is asserted.
- Counter width: cnt is CNT_W bits. The comparison with DEBOUNCE_N-1 is done at CNT_W width, so cnt never overflows.
- Reset mid-operation:
  - Any state aborts to LOW. An in-flight pulse is cancelled and StepCount is cleared.
  - If StepIn is held high across reset release, one full debounce runs and exactly one pulse is produced.
- StepIn toggling faster than DEBOUNCE_N cycles must never produce a pulse.

Decomposition:
- Shared package step_pkg:
  - state encoding constants ST_LOW=2'd0, ST_RISE_WAIT=2'd1, ST_HIGH=2'd2, ST_FALL_WAIT=2'd3.
  - default widths CNT_W=28 and STEP_W=16.
- One sub-module, sync_2ff: 2-flop synchroniser with the same Clk/Rst (async active-low, reset value 0). It is reused for other asynchronous board inputs.
- FSM, counter and outputs live in step_pulse_gen.

Test Plan:
- Reset check (DEBOUNCE_N=4), Rst=0 with StepIn=1 -> StepPulse=0, StepLevel=0, StepCount=0. Outputs are low immediately on Rst falling, with no Clk edge needed.
- Clean edge (DEBOUNCE_N=4), StepIn raised and held 20 cycles:
  - StepPulse=1 only in the cycle after edge 7; StepLevel=1 from edge 7.
  - StepCount=1; no further pulses.
  - StepIn then dropped: StepLevel=0 at edge 7 after the first low sample; StepCount stays 1.
- Bounce rejection (DEBOUNCE_N=4), StepIn high 3 cycles / low 2 cycles, repeated 10 times, then held high:
  - No pulse during the bounce.
  - Exactly one pulse 7 edges after the final rise; StepCount=1.
- Wrap (STEP_W=4, DEBOUNCE_N=1), 17 clean high/low cycles of 8 Clk each -> 17 single-cycle pulses; StepCount reads 0xF after 15 pulses, 0x0 after 16, 0x1 after 17.
- Reset mid-debounce (DEBOUNCE_N=8), Rst pulsed low during RISE_WAIT (edge 5) with StepIn held high:
  - No pulse before reset.
  - After release, exactly one pulse at edge 11 counted from release; StepCount=1.
- Async reset timing, Rst asserted between Clk edges in the cycle StepPulse=1 -> StepPulse drops within that cycle, before the next Clk edge; StepCount=0.
